hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and PC-redirect controller for the five-stage MIPS core. Compares the instruction in ID against the producers in EX and MEM and drives a one-cycle load-use stall or a multi-cycle branch-operand stall. Also handles the taken-`beq`/`j` redirect with an IF/ID flush, and whole-pipeline freeze on data-memory busy. Keeps saturating stall/flush statistics and a sticky error flag for runaway stalls.

## Interface
- `ST_W`, default 16, width of statistics counters.
- `MAX_STALL`, default 2, longest legal run of consecutive data-hazard stall cycles.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_opcode` in 6: opcode of the instruction in ID.
- `id_rs`, `id_rt` in 5 each: source register fields in ID.
- `equal` in 1: ID-stage register compare result.
- `ex_RegWrite`, `ex_memRead`, `ex_regDst` in 1 each: control bits held in ID/EX.
- `ex_rt`, `ex_rd` in 5 each: Rt/Rd held in ID/EX.
- `mem_RegWrite`, `mem_memRead` in 1 each: control bits held in EX/MEM.
- `mem_writeReg` in 5: destination register in EX/MEM.
- `mem_busy` in 1: data memory not ready.
- `clr_stats` in 1: synchronous clear of counters and the error flag.
- `pc_write` out 1: PC load enable.
- `ifid_write` out 1: IF/ID load enable.
- `ifid_flush` out 1: zero IF/ID on the next edge.
- `pipe_write` out 1: load enable for ID/EX, EX/MEM, MEM/WB.
- `idex_bubble` out 1: force zero control into ID/EX.
- `pc_sel` out 2: 00 = PC+4, 01 = branch address, 10 = jump address.
- `state` out 2: action taken last cycle.
- `stall_cnt`, `flush_cnt` out `ST_W` each: statistics.
- `hazard_err` out 1: sticky runaway-stall flag.

## Operation
- **Opcodes:**
  - R-type 000000, `beq` 000100, `j` 000010, `lw` 100011, `sw` 101011.
  - Instructions using Rt as a source: R-type, `beq`, `sw`.
  - All other opcodes use Rs only.
- **Destination and match rules:**
  - EX destination: `ex_dest` = `ex_regDst` ? `ex_rd` : `ex_rt`.
  - A match requires a nonzero register number; register 0 never hazards.
- **Load-use hazard:** `ex_memRead` and `ex_rt` matches a used source of ID.
- **Branch hazard:** `id_opcode` = `beq` and either
  - `ex_RegWrite` with `ex_dest` matching `id_rs` or `id_rt`, or
  - `mem_RegWrite` with `mem_writeReg` matching `id_rs` or `id_rt`.
  - There is no forwarding into ID, so `beq` waits until its producers have left MEM.
- **Per-cycle action, highest priority first:**
  - **FREEZE** (`mem_busy`=1): `pc_write`=`ifid_write`=`pipe_write`=0, `idex_bubble`=0, `ifid_flush`=0, `pc_sel`=00.
  - **STALL** (load-use or branch hazard): `pc_write`=`ifid_write`=0, `pipe_write`=1, `idex_bubble`=1, `ifid_flush`=0, `pc_sel`=00.
  - **REDIRECT** (`beq` with `equal`=1, or `j`): `pc_write`=`ifid_write`=`pipe_write`=1, `ifid_flush`=1, `pc_sel`=01 for `beq`, 10 for `j`.
  - **RUN**: all write enables 1, `ifid_flush`=0, `idex_bubble`=0, `pc_sel`=00.
  - Not-taken `beq` is RUN.
- **State register:**
  - Encoding RUN=00, STALL=01, FREEZE=10, REDIRECT=11.
  - Loads the action taken this cycle at the clock edge.
- **Stall-run counter (2 bits, internal):**
  - Increments on STALL, holds on FREEZE, clears on RUN or REDIRECT.
  - When a STALL cycle would make it exceed `MAX_STALL`, `hazard_err` sets and stays set.
- **Statistics counters:**
  - `stall_cnt` +1 per STALL cycle; `flush_cnt` +1 per REDIRECT cycle.
  - Both saturate at all-ones.
  - `clr_stats` zeroes both counters and `hazard_err`, and wins over a same-cycle increment or error set.

## Timing
- Enables, flush, bubble and `pc_sel` are combinational from inputs and respond in the same cycle (zero latency).
- `state`, counters and `hazard_err` update at the rising edge following the cycle in which the action occurred.
- Load-use costs exactly 1 STALL cycle.
- `beq` stall length:
  - 2 cycles when the producer is in EX.
  - 1 cycle when the producer is in MEM.
  - 2 cycles when the producer is an `lw` in EX.
- `mem_busy` during a stall freezes the stall; hazard evaluation resumes unchanged when `mem_busy` drops.
- **Reset asserted:**
  - `state`=RUN, counters 0, `hazard_err`=0, stall-run counter 0.
  - `pc_write`, `ifid_write`, `pipe_write` forced 0; `ifid_flush`, `idex_bubble`, `pc_sel` forced 0.
- **Reset deassertion:** the first clock edge after deassertion behaves as RUN if no hazard is present.

## Structure
- Shared package `mips_pkg`: opcode constants, `pc_sel` encodings, state encodings.
- One combinational sub-module, `hazard_detect`: computes `load_use`, `br_hazard`, `taken`, `is_jump`.
- `hazard_ctrl` contains the priority mux, state register, stall-run counter and statistics counters.

## Test plan
- **Load-use:** `lw $2` in EX (`ex_memRead`=1, `ex_rt`=2), `add` with `id_rs`=2 → one cycle with `pc_write`=0, `idex_bubble`=1; `state`=01 next; `stall_cnt`=1.
- **Branch after ALU op:** `beq` `id_rs`=5, EX R-type `ex_rd`=5 with `ex_regDst`=1 → STALL; producer moves to MEM → STALL; then RUN. `stall_cnt`=2, `hazard_err`=0.
- **Taken branch vs jump:** `beq` with `equal`=1, no hazards → `pc_sel`=01, `ifid_flush`=1, `flush_cnt`=1. `j` → `pc_sel`=10.
- **Freeze priority:** load-use hazard with `mem_busy`=1 for 3 cycles → all enables 0, `idex_bubble`=0, `stall_cnt` unchanged. When `mem_busy` drops → exactly one STALL.
- **Runaway and reset:**
  - Hold the load-use inputs for 3 cycles → `hazard_err`=1 after the 3rd edge.
  - `clr_stats` clears `hazard_err` and both counters.
  - Asserting `rst` mid-stall → `state`=00 immediately and all enables 0.
- **Register 0 and saturation:**
  - `ex_rt`=0 with `id_rs`=0 → no stall.
  - Preload `stall_cnt`=FFFF via repeated stalls → it stays FFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode, pc_sel and hazard-controller action encodings shared by the MIPS core.
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_FREEZE   = 2'b10,
    ST_REDIRECT = 2'b11
  } state_t;

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use / branch-operand hazard and redirect decode for ID.
`default_nettype none

module hazard_detect
  import mips_pkg::*;
(
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       equal,
  input  logic       ex_RegWrite,
  input  logic       ex_memRead,
  input  logic       ex_regDst,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rd,
  input  logic       mem_RegWrite,
  input  logic [4:0] mem_writeReg,
  output logic       load_use,
  output logic       br_hazard,
  output logic       taken,
  output logic       is_jump
);

  logic       is_beq;
  logic       rt_used;
  logic [4:0] ex_dest;
  logic       ex_hits_rs, ex_hits_rt;
  logic       mem_hits_rs, mem_hits_rt;
  logic       lw_hits_rs, lw_hits_rt;

  assign is_beq  = (id_opcode == OP_BEQ);
  assign is_jump = (id_opcode == OP_J);
  assign rt_used = uses_rt(id_opcode);
  assign ex_dest = ex_regDst ? ex_rd : ex_rt;

  // $0 is hard-wired, so a zero register number can never create a dependency.
  assign ex_hits_rs  = (ex_dest != 5'd0) && (ex_dest == id_rs);
  assign ex_hits_rt  = (ex_dest != 5'd0) && (ex_dest == id_rt);
  assign mem_hits_rs = (mem_writeReg != 5'd0) && (mem_writeReg == id_rs);
  assign mem_hits_rt = (mem_writeReg != 5'd0) && (mem_writeReg == id_rt);
  assign lw_hits_rs  = (ex_rt != 5'd0) && (ex_rt == id_rs);
  assign lw_hits_rt  = (ex_rt != 5'd0) && (ex_rt == id_rt);

  assign load_use  = ex_memRead && (lw_hits_rs || (rt_used && lw_hits_rt));
  assign br_hazard = is_beq &&
                     ((ex_RegWrite && (ex_hits_rs || ex_hits_rt)) ||
                      (mem_RegWrite && (mem_hits_rs || mem_hits_rt)));
  assign taken     = is_beq && equal;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-cycle pipeline action select (freeze/stall/redirect/run), action state,
// stall-run watchdog and saturating stall/flush statistics.
`default_nettype none

module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int ST_W      = 16,
  parameter int MAX_STALL = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      id_opcode,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            equal,
  input  logic            ex_RegWrite,
  input  logic            ex_memRead,
  input  logic            ex_regDst,
  input  logic [4:0]      ex_rt,
  input  logic [4:0]      ex_rd,
  input  logic            mem_RegWrite,
  input  logic            mem_memRead,
  input  logic [4:0]      mem_writeReg,
  input  logic            mem_busy,
  input  logic            clr_stats,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            pipe_write,
  output logic            idex_bubble,
  output logic [1:0]      pc_sel,
  output logic [1:0]      state,
  output logic [ST_W-1:0] stall_cnt,
  output logic [ST_W-1:0] flush_cnt,
  output logic            hazard_err
);

  logic   load_use, br_hazard, taken, is_jump;
  state_t action;
  state_t state_q;
  logic [1:0] run_q;
  logic       run_over;

  // Loads in MEM are already covered through mem_RegWrite/mem_writeReg.
  logic unused_mem_memread;
  assign unused_mem_memread = mem_memRead;

  hazard_detect u_detect (
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .equal        (equal),
    .ex_RegWrite  (ex_RegWrite),
    .ex_memRead   (ex_memRead),
    .ex_regDst    (ex_regDst),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .mem_RegWrite (mem_RegWrite),
    .mem_writeReg (mem_writeReg),
    .load_use     (load_use),
    .br_hazard    (br_hazard),
    .taken        (taken),
    .is_jump      (is_jump)
  );

  always_comb begin
    action = ST_RUN;
    if (mem_busy)                    action = ST_FREEZE;
    else if (load_use || br_hazard)  action = ST_STALL;
    else if (taken || is_jump)       action = ST_REDIRECT;
  end

  // Enables are zero-latency; reset holds the whole pipeline still.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    pipe_write  = 1'b0;
    idex_bubble = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    if (rst) begin
      unique case (action)
        ST_FREEZE: ;
        ST_STALL: begin
          pipe_write  = 1'b1;
          idex_bubble = 1'b1;
        end
        ST_REDIRECT: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          pipe_write = 1'b1;
          ifid_flush = 1'b1;
          pc_sel     = taken ? PC_SEL_BRANCH : PC_SEL_JUMP;
        end
        default: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          pipe_write = 1'b1;
        end
      endcase
    end
  end

  assign run_over = (action == ST_STALL) && ((int'(run_q) + 1) > MAX_STALL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      run_q      <= 2'd0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      hazard_err <= 1'b0;
    end else begin
      state_q <= action;

      case (action)
        ST_STALL:  if (run_q != 2'b11) run_q <= run_q + 2'd1;
        ST_FREEZE: run_q <= run_q;
        default:   run_q <= 2'd0;
      endcase

      if (clr_stats) begin
        stall_cnt  <= '0;
        flush_cnt  <= '0;
        hazard_err <= 1'b0;
      end else begin
        if (action == ST_STALL && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
        if (action == ST_REDIRECT && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        if (run_over) hazard_err <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire
